// File: rtl/dpu_stream_feeder.sv
// Systolic-array edge feeder: gathers BRAM words into ARRAY_DIM-lane beats, skews lane k by k cycles,
// and streams length-beat segments with software pause/resume. Optional perf counters: DPU_FEEDER_PERF_EN.
module dpu_stream_feeder #(
    parameter int BIT_WIDTH      = 8,
    parameter int ARRAY_DIM      = 32,
    parameter int RAM_WIDTH      = 32,
    parameter int RAM_ADDR_WIDTH = 12,
    parameter int STREAM_WIDTH   = 32
) (
    input  logic                           clk,
    input  logic                           sys_reset,
    input  logic                           sys_en,
    input  logic                           start,
    input  logic                           resume,
    input  logic [STREAM_WIDTH-1:0]        length,
    input  logic [STREAM_WIDTH-1:0]        total,
    input  logic [RAM_ADDR_WIDTH-1:0]      base_addr,
    input  logic [ARRAY_DIM-1:0]           pe_en,
    output logic                           ram_ren,
    output logic [RAM_ADDR_WIDTH-1:0]      ram_raddr,
    input  logic [RAM_WIDTH-1:0]           ram_dout,
    output logic [ARRAY_DIM*BIT_WIDTH-1:0] stream_data,
    output logic [ARRAY_DIM-1:0]           stream_valid,
    output logic                           started,
    output logic                           paused,
    output logic                           stream_en,
    output logic                           complete
`ifdef DPU_FEEDER_PERF_EN
    ,
    output logic [31:0]                    busy_cycles,
    output logic [31:0]                    pause_cycles
`endif
);

    localparam int LPW    = RAM_WIDTH / BIT_WIDTH;
    localparam int WPB    = ARRAY_DIM / LPW;
    localparam int WC_W   = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int FC_W   = $clog2(ARRAY_DIM + 1);
    localparam int BEAT_W = ARRAY_DIM * BIT_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EMIT  = 3'd2,
        S_PAUSE = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                    state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [WC_W-1:0]           word_cnt_q, word_cnt_d;
    logic [STREAM_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic [STREAM_WIDTH-1:0]   seg_cnt_q, seg_cnt_d;
    logic [FC_W-1:0]           flush_cnt_q, flush_cnt_d;
    logic                      cap_vld_q, cap_vld_d;
    logic [WC_W-1:0]           cap_idx_q, cap_idx_d;
    logic [BEAT_W-1:0]         gather_q, gather_d;
    logic [BEAT_W-1:0]         skew_data_q [ARRAY_DIM];
    logic [BEAT_W-1:0]         skew_data_d [ARRAY_DIM];
    logic                      skew_vld_q  [ARRAY_DIM];
    logic                      skew_vld_d  [ARRAY_DIM];
    logic                      start_ok_s;

    // Next-state, counters and word gathering
    always_comb begin
        state_d     = state_q;
        raddr_d     = raddr_q;
        word_cnt_d  = word_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        seg_cnt_d   = seg_cnt_q;
        flush_cnt_d = flush_cnt_q;
        cap_vld_d   = 1'b0;
        cap_idx_d   = word_cnt_q;
        gather_d    = gather_q;
        start_ok_s  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        // A word issued last (enabled) cycle is on ram_dout now; BRAM holds it while ren is low
        if (cap_vld_q) begin
            gather_d[int'(cap_idx_q)*RAM_WIDTH +: RAM_WIDTH] = ram_dout;
        end else begin
            gather_d = gather_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if ((length == {STREAM_WIDTH{1'b0}}) || (total == {STREAM_WIDTH{1'b0}})) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_FETCH;
                        raddr_d    = base_addr;
                        word_cnt_d = {WC_W{1'b0}};
                        beat_cnt_d = {STREAM_WIDTH{1'b0}};
                        seg_cnt_d  = {STREAM_WIDTH{1'b0}};
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_FETCH: begin
                cap_vld_d = 1'b1;
                raddr_d   = raddr_q + {{(RAM_ADDR_WIDTH-1){1'b0}}, 1'b1};
                if (word_cnt_q == WC_W'(WPB - 1)) begin
                    word_cnt_d = {WC_W{1'b0}};
                    state_d    = S_EMIT;
                end else begin
                    word_cnt_d = word_cnt_q + {{(WC_W-1){1'b0}}, 1'b1};
                end
            end
            S_EMIT: begin
                beat_cnt_d = beat_cnt_q + {{(STREAM_WIDTH-1){1'b0}}, 1'b1};
                seg_cnt_d  = seg_cnt_q + {{(STREAM_WIDTH-1){1'b0}}, 1'b1};
                if (beat_cnt_d == total) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = {FC_W{1'b0}};
                end else if (seg_cnt_d == length) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_PAUSE: begin
                if (resume) begin
                    seg_cnt_d = {STREAM_WIDTH{1'b0}};
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_PAUSE;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == FC_W'(ARRAY_DIM - 1)) begin
                    state_d = S_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + {{(FC_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Skew line: stage 0 takes the beat on EMIT, each later stage delays one more cycle
    always_comb begin
        for (int s = 0; s < ARRAY_DIM; s++) begin
            skew_data_d[s] = {BEAT_W{1'b0}};
            skew_vld_d[s]  = 1'b0;
        end
        if (state_q == S_EMIT) begin
            skew_data_d[0] = gather_d;
            skew_vld_d[0]  = 1'b1;
        end else begin
            skew_data_d[0] = {BEAT_W{1'b0}};
            skew_vld_d[0]  = 1'b0;
        end
        for (int s = 1; s < ARRAY_DIM; s++) begin
            skew_data_d[s] = skew_data_q[s-1];
            skew_vld_d[s]  = skew_vld_q[s-1];
        end
    end

    // State registers; sys_en low freezes everything
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            state_q     <= S_IDLE;
            raddr_q     <= {RAM_ADDR_WIDTH{1'b0}};
            word_cnt_q  <= {WC_W{1'b0}};
            beat_cnt_q  <= {STREAM_WIDTH{1'b0}};
            seg_cnt_q   <= {STREAM_WIDTH{1'b0}};
            flush_cnt_q <= {FC_W{1'b0}};
            cap_vld_q   <= 1'b0;
            cap_idx_q   <= {WC_W{1'b0}};
            gather_q    <= {BEAT_W{1'b0}};
            for (int s = 0; s < ARRAY_DIM; s++) begin
                skew_data_q[s] <= {BEAT_W{1'b0}};
                skew_vld_q[s]  <= 1'b0;
            end
        end else if (sys_en) begin
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            word_cnt_q  <= word_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            seg_cnt_q   <= seg_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            cap_vld_q   <= cap_vld_d;
            cap_idx_q   <= cap_idx_d;
            gather_q    <= gather_d;
            for (int s = 0; s < ARRAY_DIM; s++) begin
                skew_data_q[s] <= skew_data_d[s];
                skew_vld_q[s]  <= skew_vld_d[s];
            end
        end
    end

    // Output decode; lane k taps skew stage k and is masked by pe_en
    always_comb begin
        ram_ren   = sys_en && !sys_reset && (state_q == S_FETCH);
        ram_raddr = raddr_q;
        started   = (state_q == S_FETCH) || (state_q == S_EMIT) ||
                    (state_q == S_PAUSE) || (state_q == S_FLUSH);
        paused    = (state_q == S_PAUSE);
        stream_en = (state_q == S_FETCH) || (state_q == S_EMIT);
        complete  = (state_q == S_DONE);
        for (int k = 0; k < ARRAY_DIM; k++) begin
            stream_valid[k] = skew_vld_q[k] && pe_en[k];
            if (pe_en[k]) begin
                stream_data[k*BIT_WIDTH +: BIT_WIDTH] = skew_data_q[k][k*BIT_WIDTH +: BIT_WIDTH];
            end else begin
                stream_data[k*BIT_WIDTH +: BIT_WIDTH] = {BIT_WIDTH{1'b0}};
            end
        end
    end

`ifdef DPU_FEEDER_PERF_EN
    logic [31:0] busy_q, busy_d;
    logic [31:0] pause_q, pause_d;

    // Saturating activity counters, cleared by an accepted start
    always_comb begin
        busy_d  = busy_q;
        pause_d = pause_q;
        if (start_ok_s) begin
            busy_d  = 32'd0;
            pause_d = 32'd0;
        end else begin
            if (started && (busy_q != 32'hFFFF_FFFF)) begin
                busy_d = busy_q + 32'd1;
            end else begin
                busy_d = busy_q;
            end
            if (paused && (pause_q != 32'hFFFF_FFFF)) begin
                pause_d = pause_q + 32'd1;
            end else begin
                pause_d = pause_q;
            end
        end
    end

    // Perf counter registers
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            busy_q  <= 32'd0;
            pause_q <= 32'd0;
        end else if (sys_en) begin
            busy_q  <= busy_d;
            pause_q <= pause_d;
        end
    end

    assign busy_cycles  = busy_q;
    assign pause_cycles = pause_q;
`endif

endmodule

// File: tb/tb_dpu_stream_feeder.sv
// Scoreboard bench for dpu_stream_feeder (ARRAY_DIM=16, 4 words per beat): expected reads and lane
// bytes are queued when a run is launched and checked as the feeder produces them.
module tb_dpu_stream_feeder;

    localparam int BW  = 8;
    localparam int AD  = 16;
    localparam int RW  = 32;
    localparam int AW  = 12;
    localparam int SW  = 32;
    localparam int LPW = RW / BW;
    localparam int WPB = AD / LPW;

    logic              clk = 1'b0;
    logic              sys_reset, sys_en, start, resume;
    logic [SW-1:0]     length, total;
    logic [AW-1:0]     base_addr;
    logic [AD-1:0]     pe_en;
    logic              ram_ren;
    logic [AW-1:0]     ram_raddr;
    logic [RW-1:0]     ram_dout;
    logic [AD*BW-1:0]  stream_data;
    logic [AD-1:0]     stream_valid;
    logic              started, paused, stream_en, complete;
`ifdef DPU_FEEDER_PERF_EN
    logic [31:0]       busy_cycles, pause_cycles;
`endif

    logic [RW-1:0]     mem [0:(1<<AW)-1];
    int                total_n = 0;
    int                bad_n   = 0;
    int                cyc     = 0;
    int                ren_cnt = 0;
    logic [BW-1:0]     exp_data [AD][$];
    int                exp_cyc  [AD][$];
    logic [AW-1:0]     exp_addr [$];
    logic [AW-1:0]     mon_a;
    logic [BW-1:0]     mon_d;
    int                mon_c;

    dpu_stream_feeder #(
        .BIT_WIDTH(BW), .ARRAY_DIM(AD), .RAM_WIDTH(RW), .RAM_ADDR_WIDTH(AW), .STREAM_WIDTH(SW)
    ) dut (
        .clk(clk), .sys_reset(sys_reset), .sys_en(sys_en), .start(start), .resume(resume),
        .length(length), .total(total), .base_addr(base_addr), .pe_en(pe_en),
        .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_dout(ram_dout),
        .stream_data(stream_data), .stream_valid(stream_valid),
        .started(started), .paused(paused), .stream_en(stream_en), .complete(complete)
`ifdef DPU_FEEDER_PERF_EN
        , .busy_cycles(busy_cycles), .pause_cycles(pause_cycles)
`endif
    );

    always #5 clk = ~clk;

    // BRAM model (output holds when not read) and cycle index
    always @(posedge clk) begin
        if (ram_ren) ram_dout <= mem[ram_raddr];
        cyc <= cyc + 1;
    end

    // Scoreboard monitor: reads and lane outputs, on the falling edge of enabled cycles
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!sys_reset && sys_en) begin
                if (ram_ren) begin
                    ren_cnt++;
                    total_n++;
                    if (exp_addr.size() == 0) begin
                        bad_n++;
                        $display("FAIL rd_addr: unexpected read at %0d (cycle %0d)", ram_raddr, cyc);
                    end else begin
                        mon_a = exp_addr.pop_front();
                        if (ram_raddr !== mon_a) begin
                            bad_n++;
                            $display("FAIL rd_addr: got %0d expected %0d", ram_raddr, mon_a);
                        end
                    end
                end
                for (int k = 0; k < AD; k++) begin
                    if (stream_valid[k]) begin
                        total_n++;
                        if (exp_data[k].size() == 0) begin
                            bad_n++;
                            $display("FAIL lane_valid: lane %0d valid with nothing expected (cycle %0d)", k, cyc);
                        end else begin
                            mon_d = exp_data[k].pop_front();
                            mon_c = exp_cyc[k].pop_front();
                            if (stream_data[k*BW +: BW] !== mon_d || (mon_c >= 0 && mon_c != cyc)) begin
                                bad_n++;
                                $display("FAIL lane_data: lane %0d got %0h at cycle %0d, expected %0h at cycle %0d",
                                         k, stream_data[k*BW +: BW], cyc, mon_d, mon_c);
                            end
                        end
                    end else if (!pe_en[k]) begin
                        total_n++;
                        if (stream_data[k*BW +: BW] !== '0) begin
                            bad_n++;
                            $display("FAIL masked_data: lane %0d got %0h expected 0", k, stream_data[k*BW +: BW]);
                        end
                    end
                end
            end
        end
    end

    function automatic int pending();
        int n = exp_addr.size();
        for (int k = 0; k < AD; k++) n += exp_data[k].size();
        return n;
    endfunction

    // Caller is 1 time unit after a rising edge; returns one cycle later with start dropped
    task automatic launch(input logic [AW-1:0] b, input int len, input int tot, input logic timed,
                          output int s0);
        int nb;
        logic [AW-1:0] a;
        logic [RW-1:0] w;
        base_addr = b;
        length    = SW'(len);
        total     = SW'(tot);
        start     = 1'b1;
        s0        = cyc;
        nb        = (len == 0 || tot == 0) ? 0 : tot;
        for (int bt = 0; bt < nb; bt++) begin
            for (int wi = 0; wi < WPB; wi++) exp_addr.push_back(b + AW'(bt*WPB + wi));
            for (int k = 0; k < AD; k++) begin
                if (pe_en[k]) begin
                    a = b + AW'(bt*WPB + k/LPW);
                    w = mem[a];
                    exp_data[k].push_back(w[(k%LPW)*BW +: BW]);
                    exp_cyc[k].push_back(timed ? s0 + bt*(WPB+1) + WPB + 2 + k : -1);
                end
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_sig(input int which, input int budget, output logic ok, output int at);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            if ((which == 0) ? complete : paused) begin
                ok = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic test_reset();
        sys_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_n++;
        if ({ram_ren, started, paused, stream_en, complete} !== 5'b0) begin
            bad_n++;
            $display("FAIL reset_status: got %b expected 00000", {ram_ren, started, paused, stream_en, complete});
        end
        total_n++;
        if (ram_raddr !== '0 || stream_valid !== '0 || stream_data !== '0) begin
            bad_n++;
            $display("FAIL reset_outputs: raddr=%0h valid=%0h data=%0h expected all 0", ram_raddr, stream_valid, stream_data);
        end
        sys_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_n++;
        if ({ram_ren, started, complete} !== 3'b0) begin
            bad_n++;
            $display("FAIL idle_status: got %b expected 000", {ram_ren, started, complete});
        end
    endtask

    task automatic test_single_beat();
        int s0, at, r0;
        logic ok;
        r0 = ren_cnt;
        launch(12'd0, 1, 1, 1'b1, s0);
        wait_sig(0, 100, ok, at);
        total_n++;
        if (ok !== 1'b1 || at != s0 + WPB + AD + 2) begin
            bad_n++;
            $display("FAIL single_done: complete at cycle %0d expected %0d", at, s0 + WPB + AD + 2);
        end
        total_n++;
        if (ren_cnt - r0 != WPB) begin
            bad_n++;
            $display("FAIL single_reads: got %0d reads expected %0d", ren_cnt - r0, WPB);
        end
        total_n++;
        if (pending() != 0) begin
            bad_n++;
            $display("FAIL single_drain: %0d entries left expected 0", pending());
        end
    endtask

    task automatic test_back_to_back();
        int s0, at, exp_at;
        logic ok;
        launch(12'd0, 3, 3, 1'b1, s0);
        total_n++;
        if ({complete, started} !== 2'b01) begin
            bad_n++;
            $display("FAIL relaunch: complete,started got %b expected 01", {complete, started});
        end
        exp_at = s0 + 2*(WPB+1) + WPB + AD + 2;
        wait_sig(0, 200, ok, at);
        total_n++;
        if (ok !== 1'b1 || at != exp_at) begin
            bad_n++;
            $display("FAIL b2b_done: complete at cycle %0d expected %0d", at, exp_at);
        end
        total_n++;
        if (pending() != 0) begin
            bad_n++;
            $display("FAIL b2b_drain: %0d entries left expected 0", pending());
        end
    endtask

    task automatic test_pause_resume();
        int s0, at;
        logic ok;
        logic [AW-1:0] nxt;
        launch(12'd100, 1, 3, 1'b0, s0);
        for (int p = 0; p < 2; p++) begin
            nxt = AW'(100 + (p+1)*WPB);
            wait_sig(1, 60, ok, at);
            total_n++;
            if (ok !== 1'b1 || ram_raddr !== nxt) begin
                bad_n++;
                $display("FAIL pause_entry: paused=%b raddr=%0d expected 1 and %0d", ok, ram_raddr, nxt);
            end
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                total_n++;
                if ({paused, ram_ren} !== 2'b10) begin
                    bad_n++;
                    $display("FAIL pause_hold: paused,ren got %b expected 10", {paused, ram_ren});
                end
            end
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            total_n++;
            if (paused !== 1'b1) begin
                bad_n++;
                $display("FAIL pause_start_ignored: paused got %b expected 1", paused);
            end
            resume = 1'b1;
            @(posedge clk); #1;
            resume = 1'b0;
            total_n++;
            if ({paused, ram_ren} !== 2'b01 || ram_raddr !== nxt) begin
                bad_n++;
                $display("FAIL resume: paused,ren=%b raddr=%0d expected 01 and %0d", {paused, ram_ren}, ram_raddr, nxt);
            end
        end
        wait_sig(0, 200, ok, at);
        total_n++;
        if (ok !== 1'b1 || pending() != 0) begin
            bad_n++;
            $display("FAIL pause_done: complete=%b pending=%0d expected 1 and 0", ok, pending());
        end
    endtask

    task automatic test_addr_wrap();
        int s0, at;
        logic ok;
        launch(12'd4094, 2, 2, 1'b1, s0);
        wait_sig(0, 200, ok, at);
        total_n++;
        if (ok !== 1'b1 || pending() != 0 || ram_raddr !== 12'd6) begin
            bad_n++;
            $display("FAIL wrap: complete=%b pending=%0d raddr=%0d expected 1, 0, 6", ok, pending(), ram_raddr);
        end
    endtask

    task automatic test_mask_freeze();
        int s0, at;
        logic ok;
        logic [AW-1:0] hold_a;
        logic [AD-1:0] hold_v;
        pe_en = 16'h5555;
        launch(12'd200, 2, 2, 1'b0, s0);
        repeat (7) @(posedge clk);
        #1;
        sys_en = 1'b0;
        hold_a = ram_raddr;
        hold_v = stream_valid;
        total_n++;
        if (hold_v === '0) begin
            bad_n++;
            $display("FAIL freeze_setup: valid got %0h expected nonzero", hold_v);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total_n++;
            if (ram_ren !== 1'b0 || ram_raddr !== hold_a || stream_valid !== hold_v || stream_en !== 1'b1) begin
                bad_n++;
                $display("FAIL freeze: ren=%b raddr=%0d valid=%0h expected 0, %0d, %0h", ram_ren, ram_raddr, stream_valid, hold_a, hold_v);
            end
        end
        sys_en = 1'b1;
        wait_sig(0, 200, ok, at);
        total_n++;
        if (ok !== 1'b1 || pending() != 0) begin
            bad_n++;
            $display("FAIL mask_done: complete=%b pending=%0d expected 1 and 0", ok, pending());
        end
        pe_en = '1;
    endtask

    task automatic test_reset_flush();
        int s0, at, r0;
        logic ok;
        launch(12'd300, 1, 1, 1'b1, s0);
        repeat (WPB + 4) @(posedge clk);
        #1;
        total_n++;
        if ({started, stream_en} !== 2'b10) begin
            bad_n++;
            $display("FAIL flush_state: started,stream_en got %b expected 10", {started, stream_en});
        end
        sys_reset = 1'b1;
        @(posedge clk); #1;
        sys_reset = 1'b0;
        total_n++;
        if ({ram_ren, started, paused, stream_en, complete} !== 5'b0 || stream_valid !== '0 ||
            stream_data !== '0 || ram_raddr !== '0) begin
            bad_n++;
            $display("FAIL flush_reset: status=%b valid=%0h raddr=%0d expected all 0",
                     {ram_ren, started, paused, stream_en, complete}, stream_valid, ram_raddr);
        end
        exp_addr.delete();
        for (int k = 0; k < AD; k++) begin
            exp_data[k].delete();
            exp_cyc[k].delete();
        end
        launch(12'd300, 1, 1, 1'b1, s0);
        wait_sig(0, 100, ok, at);
        total_n++;
        if (ok !== 1'b1 || at != s0 + WPB + AD + 2 || pending() != 0) begin
            bad_n++;
            $display("FAIL relaunch_done: complete at %0d pending=%0d expected %0d and 0", at, pending(), s0 + WPB + AD + 2);
        end
        sys_reset = 1'b1;
        @(posedge clk); #1;
        sys_reset = 1'b0;
        r0 = ren_cnt;
        launch(12'd0, 0, 5, 1'b0, s0);
        total_n++;
        if ({complete, started} !== 2'b10) begin
            bad_n++;
            $display("FAIL zero_length: complete,started got %b expected 10", {complete, started});
        end
        repeat (3) @(posedge clk);
        #1;
        total_n++;
        if (ren_cnt != r0 || complete !== 1'b1) begin
            bad_n++;
            $display("FAIL zero_length_reads: reads=%0d complete=%b expected 0 and 1", ren_cnt - r0, complete);
        end
    endtask

    initial begin
        sys_reset = 1'b1;
        sys_en    = 1'b1;
        start     = 1'b0;
        resume    = 1'b0;
        length    = 32'd1;
        total     = 32'd1;
        base_addr = 12'd0;
        pe_en     = '1;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[0] = 32'h0403_0201;
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_pause_resume();
        test_addr_wrap();
        test_mask_freeze();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
